// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of hazard sources and the stall/flush/redirect
// controls returned by the hazard controller.
interface hazard_stall_ctrl_if #(
   parameter int ADDR_W = 2,
   parameter int CNT_W  = 16
);
   logic [ADDR_W-1:0] id_rs;
   logic [ADDR_W-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic              idex_memread;
   logic [ADDR_W-1:0] idex_wr_addr;
   logic              ex_mispredict;
   logic              id_jump;
   logic              i_ready;
   logic              d_req;
   logic              d_ready;
   logic              wb_halt;

   logic              stall_pc;
   logic              stall_ifid;
   logic              stall_idex;
   logic              stall_exmem;
   logic              flush_ifid;
   logic              flush_idex;
   logic              flush_exmem;
   logic              flush_memwb;
   logic              pc_redirect;
   logic              halted;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   // Datapath side: reports hazard sources, consumes the controls.
   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, idex_memread, idex_wr_addr,
             ex_mispredict, id_jump, i_ready, d_req, d_ready, wb_halt,
      input  stall_pc, stall_ifid, stall_idex, stall_exmem,
             flush_ifid, flush_idex, flush_exmem, flush_memwb,
             pc_redirect, halted, stall_count, flush_count
   );

   // Controller side.
   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, idex_memread, idex_wr_addr,
             ex_mispredict, id_jump, i_ready, d_req, d_ready, wb_halt,
      output stall_pc, stall_ifid, stall_idex, stall_exmem,
             flush_ifid, flush_idex, flush_exmem, flush_memwb,
             pc_redirect, halted, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: same-cycle stall/flush/redirect controls,
// wrong-path fetch tracking and saturating stall/flush statistics.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal operation, controls driven from current hazards
// SQUASH | fetch issued before a redirect is still in flight; discard it
// HALT   | HLT retired; pipeline frozen until reset
module hazard_stall_ctrl #(
   parameter int ADDR_W = 2,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   hazard_stall_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SQUASH = 2'd1,
      HALT   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;
   logic [CNT_W-1:0]  flush_count_q, flush_count_d;

   logic dwait;
   logic loaduse;
   logic in_squash;

   logic stall_pc_c, stall_ifid_c, stall_idex_c, stall_exmem_c;
   logic flush_ifid_c, flush_idex_c, flush_exmem_c, flush_memwb_c;
   logic pc_redirect_c;
   logic flush_evt_c;

   assign dwait     = hz.d_req & ~hz.d_ready;
   assign loaduse   = hz.idex_memread &
                      ((hz.id_use_rs & (hz.id_rs == hz.idex_wr_addr)) |
                       (hz.id_use_rt & (hz.id_rt == hz.idex_wr_addr)));
   assign in_squash = (state_q == SQUASH);

   // State and statistics registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   // Next state; a completing fetch ends SQUASH unless a new redirect
   // has been issued in the same cycle.
   always_comb begin
      state_d = state_q;
      if (state_q != HALT) begin
         if (hz.wb_halt) begin
            state_d = HALT;
         end else if (dwait) begin
            if (in_squash && hz.i_ready) state_d = RUN;
         end else if (hz.ex_mispredict) begin
            if (in_squash || !hz.i_ready) state_d = SQUASH;
         end else if (in_squash && hz.i_ready) begin
            state_d = RUN;
         end
      end
   end

   // Mealy stall/flush/redirect controls in priority order.
   always_comb begin
      stall_pc_c    = 1'b0;
      stall_ifid_c  = 1'b0;
      stall_idex_c  = 1'b0;
      stall_exmem_c = 1'b0;
      flush_ifid_c  = 1'b0;
      flush_idex_c  = 1'b0;
      flush_exmem_c = 1'b0;
      flush_memwb_c = 1'b0;
      pc_redirect_c = 1'b0;
      flush_evt_c   = 1'b0;
      if (!reset) begin
         if (state_q == HALT || hz.wb_halt) begin
            stall_pc_c    = 1'b1;
            stall_ifid_c  = 1'b1;
            stall_idex_c  = 1'b1;
            stall_exmem_c = 1'b1;
         end else if (dwait) begin
            // The branch stays parked in EX; its redirect waits for d_ready.
            stall_pc_c    = 1'b1;
            stall_ifid_c  = 1'b1;
            stall_idex_c  = 1'b1;
            stall_exmem_c = 1'b1;
            flush_memwb_c = 1'b1;
         end else if (hz.ex_mispredict) begin
            flush_ifid_c  = 1'b1;
            flush_idex_c  = 1'b1;
            pc_redirect_c = 1'b1;
            flush_evt_c   = 1'b1;
         end else begin
            if (loaduse) begin
               stall_pc_c   = 1'b1;
               stall_ifid_c = 1'b1;
               flush_idex_c = 1'b1;
            end else if (hz.id_jump) begin
               flush_ifid_c = 1'b1;
               flush_evt_c  = 1'b1;
            end
            // Missing or wrong-path fetch: hold PC, feed a bubble into ID.
            if (!hz.i_ready || in_squash) begin
               stall_pc_c   = 1'b1;
               flush_ifid_c = 1'b1;
            end
         end
      end
   end

   // Saturating statistics; frozen while halted.
   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (state_q != HALT) begin
         if (stall_pc_c && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + 1'b1;
         if (flush_evt_c && (flush_count_q != {CNT_W{1'b1}}))
            flush_count_d = flush_count_q + 1'b1;
      end
   end

   assign hz.stall_pc    = stall_pc_c;
   assign hz.stall_ifid  = stall_ifid_c;
   assign hz.stall_idex  = stall_idex_c;
   assign hz.stall_exmem = stall_exmem_c;
   assign hz.flush_ifid  = flush_ifid_c;
   assign hz.flush_idex  = flush_idex_c;
   assign hz.flush_exmem = flush_exmem_c;
   assign hz.flush_memwb = flush_memwb_c;
   assign hz.pc_redirect = pc_redirect_c;
   assign hz.halted      = (state_q == HALT);
   assign hz.stall_count = stall_count_q;
   assign hz.flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;

   logic clk = 1'b0;
   logic reset;

   hazard_stall_ctrl_if #(.ADDR_W(2), .CNT_W(16)) hz ();

   hazard_stall_ctrl #(.ADDR_W(2), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   always #5 clk = ~clk;

   // Control vector order: stall_pc stall_ifid stall_idex stall_exmem
   //                       flush_ifid flush_idex flush_exmem flush_memwb pc_redirect
   localparam logic [8:0] SPC = 9'b1_0000_0000;
   localparam logic [8:0] SIF = 9'b0_1000_0000;
   localparam logic [8:0] SIE = 9'b0_0100_0000;
   localparam logic [8:0] SEM = 9'b0_0010_0000;
   localparam logic [8:0] FIF = 9'b0_0001_0000;
   localparam logic [8:0] FIE = 9'b0_0000_1000;
   localparam logic [8:0] FMW = 9'b0_0000_0010;
   localparam logic [8:0] RED = 9'b0_0000_0001;
   localparam logic [8:0] ALLS = SPC | SIF | SIE | SEM;
   localparam logic [8:0] NONE = 9'b0;

   int tests  = 0;
   int failed = 0;

   function automatic logic [8:0] ctl();
      return {hz.stall_pc, hz.stall_ifid, hz.stall_idex, hz.stall_exmem,
              hz.flush_ifid, hz.flush_idex, hz.flush_exmem, hz.flush_memwb,
              hz.pc_redirect};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      hz.id_rs = 2'd0; hz.id_rt = 2'd0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
      hz.idex_memread = 1'b0; hz.idex_wr_addr = 2'd0;
      hz.ex_mispredict = 1'b0; hz.id_jump = 1'b0; hz.i_ready = 1'b1;
      hz.d_req = 1'b0; hz.d_ready = 1'b0; hz.wb_halt = 1'b0;
   endtask

   // Inputs change 1 time unit after the edge; controls are sampled 2 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #1;
      // Outputs forced low during reset even with a fetch miss pending.
      hz.i_ready = 1'b0;
      hz.ex_mispredict = 1'b1;
      settle(); chk("reset_ctl", 32'(ctl()), 32'(NONE));
      tick();
      tick();
      chk("reset_halted", 32'(hz.halted), 32'd0);
      chk("reset_stall_cnt", 32'(hz.stall_count), 32'd0);
      chk("reset_flush_cnt", 32'(hz.flush_count), 32'd0);
      idle();
      reset = 1'b0;
      settle(); chk("idle_ctl", 32'(ctl()), 32'(NONE));

      // Load-use on rs for one cycle.
      tick();
      hz.idex_memread = 1'b1; hz.idex_wr_addr = 2'd2; hz.id_rs = 2'd2; hz.id_use_rs = 1'b1;
      settle(); chk("loaduse_ctl", 32'(ctl()), 32'(SPC | SIF | FIE));
      tick();
      idle();
      settle(); chk("loaduse_gone", 32'(ctl()), 32'(NONE));
      chk("loaduse_stall_cnt", 32'(hz.stall_count), 32'd1);
      // Matching rt but not used, rs used but different: no hazard.
      hz.idex_memread = 1'b1; hz.idex_wr_addr = 2'd3; hz.id_rt = 2'd3; hz.id_rs = 2'd1;
      hz.id_use_rs = 1'b1; hz.id_use_rt = 1'b0;
      settle(); chk("loaduse_nomatch", 32'(ctl()), 32'(NONE));
      // rt hazard combined with a fetch miss.
      hz.id_use_rt = 1'b1; hz.i_ready = 1'b0;
      settle(); chk("loaduse_imiss", 32'(ctl()), 32'(SPC | SIF | FIE | FIF));
      tick();
      idle();
      // Jump in ID.
      hz.id_jump = 1'b1;
      settle(); chk("jump_ctl", 32'(ctl()), 32'(FIF));
      tick();
      idle();
      settle();
      chk("jump_flush_cnt", 32'(hz.flush_count), 32'd1);
      chk("jump_stall_cnt", 32'(hz.stall_count), 32'd2);

      // D-cache miss with a mispredict held in EX.
      do_reset();
      hz.d_req = 1'b1; hz.d_ready = 1'b0; hz.ex_mispredict = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle(); chk($sformatf("dmiss_ctl%0d", i), 32'(ctl()), 32'(ALLS | FMW));
         tick();
      end
      hz.d_ready = 1'b1;
      settle(); chk("dmiss_release", 32'(ctl()), 32'(FIF | FIE | RED));
      tick();
      idle();
      settle();
      chk("dmiss_flush_cnt", 32'(hz.flush_count), 32'd1);
      chk("dmiss_stall_cnt", 32'(hz.stall_count), 32'd3);
      chk("dmiss_after", 32'(ctl()), 32'(NONE));

      // Mispredict with fetch outstanding -> SQUASH for 3 cycles.
      do_reset();
      hz.ex_mispredict = 1'b1; hz.i_ready = 1'b0;
      settle(); chk("sq_mispredict", 32'(ctl()), 32'(FIF | FIE | RED));
      tick();
      hz.ex_mispredict = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle(); chk($sformatf("sq_wait%0d", i), 32'(ctl()), 32'(SPC | FIF));
         tick();
      end
      hz.i_ready = 1'b1;
      settle(); chk("sq_arrive", 32'(ctl()), 32'(SPC | FIF));
      tick();
      settle();
      chk("sq_back_run", 32'(ctl()), 32'(NONE));
      chk("sq_stall_cnt", 32'(hz.stall_count), 32'd3);
      chk("sq_flush_cnt", 32'(hz.flush_count), 32'd1);

      // Mispredict beats load-use.
      hz.ex_mispredict = 1'b1;
      hz.idex_memread = 1'b1; hz.idex_wr_addr = 2'd1; hz.id_rs = 2'd1; hz.id_use_rs = 1'b1;
      settle(); chk("mp_over_lu", 32'(ctl()), 32'(FIF | FIE | RED));
      tick();
      idle();

      // Halt is sticky; mispredicts ignored and counters frozen.
      do_reset();
      hz.wb_halt = 1'b1;
      settle(); chk("halt_cycle", 32'(ctl()), 32'(ALLS));
      tick();
      hz.wb_halt = 1'b0; hz.ex_mispredict = 1'b1; hz.id_jump = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk($sformatf("halt_ctl%0d", i), 32'(ctl()), 32'(ALLS));
         chk($sformatf("halt_flag%0d", i), 32'(hz.halted), 32'd1);
         tick();
      end
      settle();
      chk("halt_stall_frozen", 32'(hz.stall_count), 32'd1);
      chk("halt_flush_frozen", 32'(hz.flush_count), 32'd0);
      reset = 1'b1;
      settle(); chk("halt_reset_ctl", 32'(ctl()), 32'(NONE));
      tick();
      reset = 1'b0;
      idle();
      settle();
      chk("halt_cleared", 32'(hz.halted), 32'd0);
      chk("halt_cnt_clear", 32'(hz.stall_count), 32'd0);
      chk("halt_run_ctl", 32'(ctl()), 32'(NONE));

      // Stall counter saturation.
      hz.i_ready = 1'b0;
      for (int i = 0; i < 65534; i++) tick();
      settle(); chk("sat_near", 32'(hz.stall_count), 32'h0000_FFFE);
      for (int i = 0; i < 6; i++) tick();
      settle(); chk("sat_full", 32'(hz.stall_count), 32'h0000_FFFF);
      chk("sat_ctl", 32'(ctl()), 32'(SPC | FIF));
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
